// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the memory access sequencer: bus width and FSM state encoding.
// StError is only reachable when MEM_TIMEOUT_EN is defined.
package mem_access_sequencer_pkg;

  localparam int unsigned WordSize = 16;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StExec   = 3'd2,
    StRead   = 3'd3,
    StWrite  = 3'd4,
    StCommit = 3'd5,
    StError  = 3'd6
  } state_e;

  // States in which the sequencer owns the bus and waits for the memory.
  function automatic logic is_wait_state(state_e s);
    return (s == StFetch) || (s == StRead) || (s == StWrite);
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Shared memory port between the sequencer (master) and the memory (slave).
interface mem_access_sequencer_if #(
  parameter int unsigned WORD_SIZE = 16
);
  logic                 readM;
  logic                 writeM;
  logic [WORD_SIZE-1:0] address;
  logic [WORD_SIZE-1:0] data_out;
  logic                 data_oe;
  logic [WORD_SIZE-1:0] data_in;
  logic                 inputReady;
  logic                 ackOutput;

  modport master (
    output readM, writeM, address, data_out, data_oe,
    input  data_in, inputReady, ackOutput
  );

  modport slave (
    input  readM, writeM, address, data_out, data_oe,
    output data_in, inputReady, ackOutput
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the sequencer; flags expiry on the TIMEOUT_CYCLES-th waiting cycle.
// Only built when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + 1'b1;
    end
  end

  // Fires during the waiting cycle that brings the count up to TIMEOUT_CYCLES.
  assign expired = tick && (count_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule
`endif

// File: rtl/mem_access_sequencer.sv
// Moore FSM sequencing the CPU's shared memory port: fetch, optional load/store, commit.
// Define MEM_TIMEOUT_EN to add a wait timeout that parks the FSM in StError until reset.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = WordSize,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [WORD_SIZE-1:0]   pc,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [WORD_SIZE-1:0]   data_addr,
  input  logic [WORD_SIZE-1:0]   wdata,
  output logic [WORD_SIZE-1:0]   inst,
  output logic                   inst_valid,
  output logic [WORD_SIZE-1:0]   rdata,
  output logic                   commit,
  output logic                   err,
  mem_access_sequencer_if.master bus
);

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] inst_q, inst_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 inst_valid_q, inst_valid_d;
  logic                 err_q, err_d;
  logic                 timeout;

`ifdef MEM_TIMEOUT_EN
  logic waiting;
  logic ready;

  assign waiting = is_wait_state(state_q);
  assign ready   = (state_q == StWrite) ? bus.ackOutput : bus.inputReady;

  // Holding clear outside the wait states zeroes the count on every entry.
  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (~waiting),
    .tick   (waiting & ~ready),
    .expired(timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    rdata_d      = rdata_q;
    inst_valid_d = inst_valid_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (bus.inputReady) begin
          inst_d       = bus.data_in;
          inst_valid_d = 1'b1;
          state_d      = StExec;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StError;
        end
      end
      StExec: begin
        if (mem_write) begin
          // A store that also claims to be a load is a decode fault; the store wins.
          if (mem_read) err_d = 1'b1;
          state_d = StWrite;
        end else if (mem_read) begin
          state_d = StRead;
        end else begin
          state_d = StCommit;
        end
      end
      StRead: begin
        if (bus.inputReady) begin
          rdata_d = bus.data_in;
          state_d = StCommit;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StError;
        end
      end
      StWrite: begin
        if (bus.ackOutput) begin
          state_d = StCommit;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StError;
        end
      end
      StCommit: begin
        inst_valid_d = 1'b0;
        state_d      = run ? StFetch : StIdle;
      end
      StError: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      inst_q       <= '0;
      rdata_q      <= '0;
      inst_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      rdata_q      <= rdata_d;
      inst_valid_q <= inst_valid_d;
      err_q        <= err_d;
    end
  end

  // Bus outputs depend only on the registered state (and the CPU's held operands).
  logic                 read_req;
  logic                 write_req;
  logic [WORD_SIZE-1:0] addr_mux;

  always_comb begin
    read_req  = 1'b0;
    write_req = 1'b0;
    addr_mux  = '0;
    unique case (state_q)
      StFetch: begin
        read_req = 1'b1;
        addr_mux = pc;
      end
      StRead: begin
        read_req = 1'b1;
        addr_mux = data_addr;
      end
      StWrite: begin
        write_req = 1'b1;
        addr_mux  = data_addr;
      end
      default: ;
    endcase
  end

  assign bus.readM    = read_req;
  assign bus.writeM   = write_req;
  assign bus.data_oe  = write_req;
  assign bus.address  = addr_mux;
  assign bus.data_out = write_req ? wdata : '0;

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign rdata      = rdata_q;
  assign err        = err_q;
  assign commit     = (state_q == StCommit);

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed self-checking bench for mem_access_sequencer; timeout case runs under MEM_TIMEOUT_EN.
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] pc;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] data_addr;
  logic [15:0] wdata;
  logic [15:0] inst;
  logic        inst_valid;
  logic [15:0] rdata;
  logic        commit;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int rd_cycles = 0;
  int wr_cycles = 0;
  int commits = 0;

  always #5 clk = ~clk;

  mem_access_sequencer_if #(.WORD_SIZE(16)) bus ();

  mem_access_sequencer #(
    .WORD_SIZE     (16),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .pc        (pc),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .data_addr (data_addr),
    .wdata     (wdata),
    .inst      (inst),
    .inst_valid(inst_valid),
    .rdata     (rdata),
    .commit    (commit),
    .err       (err),
    .bus       (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    rd_cycles = 0;
    wr_cycles = 0;
    commits   = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.readM) rd_cycles++;
      if (bus.writeM) wr_cycles++;
      if (commit) commits++;
      check_eq("rw_overlap", {31'd0, bus.readM & bus.writeM}, 32'd0);
    end
  end

  initial begin
    reset = 1'b1; run = 1'b0; pc = '0; mem_read = 1'b0; mem_write = 1'b0;
    data_addr = '0; wdata = '0;
    bus.data_in = '0; bus.inputReady = 1'b0; bus.ackOutput = 1'b0;
    tick(); tick();

    // Reset state
    check_eq("rst_readM", bus.readM, 0);
    check_eq("rst_writeM", bus.writeM, 0);
    check_eq("rst_data_oe", bus.data_oe, 0);
    check_eq("rst_address", bus.address, 16'h0000);
    check_eq("rst_data_out", bus.data_out, 16'h0000);
    check_eq("rst_commit", commit, 0);
    check_eq("rst_inst_valid", inst_valid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_inst", inst, 16'h0000);
    check_eq("rst_rdata", rdata, 16'h0000);
    reset = 1'b0;

    // 1: ALU instruction, fetch with two wait cycles
    clear_counts();
    pc = 16'h0010; run = 1'b1;
    tick();                                   // FETCH, wait 1
    run = 1'b0;
    check_eq("t1_readM", bus.readM, 1);
    check_eq("t1_addr", bus.address, 16'h0010);
    tick();                                   // FETCH, wait 2
    check_eq("t1_readM_w2", bus.readM, 1);
    tick();                                   // FETCH, data ready
    bus.inputReady = 1'b1; bus.data_in = 16'h6A05;
    tick();                                   // EXEC
    bus.inputReady = 1'b0; bus.data_in = 16'h0000;
    check_eq("t1_exec_readM", bus.readM, 0);
    check_eq("t1_inst", inst, 16'h6A05);
    check_eq("t1_inst_valid", inst_valid, 1);
    check_eq("t1_exec_commit", commit, 0);
    tick();                                   // COMMIT
    check_eq("t1_commit", commit, 1);
    check_eq("t1_commit_iv", inst_valid, 1);
    tick();                                   // IDLE
    check_eq("t1_idle_commit", commit, 0);
    check_eq("t1_idle_iv", inst_valid, 0);
    check_eq("t1_rd_cycles", rd_cycles, 3);
    check_eq("t1_commits", commits, 1);

    // 2: load
    clear_counts();
    pc = 16'h0011; run = 1'b1; mem_read = 1'b1; data_addr = 16'h0040;
    tick();                                   // FETCH
    run = 1'b0;
    bus.inputReady = 1'b1; bus.data_in = 16'h1111;
    tick();                                   // EXEC
    bus.inputReady = 1'b0;
    check_eq("t2_inst", inst, 16'h1111);
    tick();                                   // READ
    check_eq("t2_read_readM", bus.readM, 1);
    check_eq("t2_read_addr", bus.address, 16'h0040);
    check_eq("t2_read_writeM", bus.writeM, 0);
    bus.inputReady = 1'b1; bus.data_in = 16'hBEEF;
    tick();                                   // COMMIT
    bus.inputReady = 1'b0; bus.data_in = 16'h0000; mem_read = 1'b0;
    check_eq("t2_rdata", rdata, 16'hBEEF);
    check_eq("t2_commit", commit, 1);
    check_eq("t2_commit_readM", bus.readM, 0);
    tick();                                   // IDLE
    check_eq("t2_rd_cycles", rd_cycles, 2);
    check_eq("t2_commits", commits, 1);

    // 3: store, ack after one cycle
    clear_counts();
    pc = 16'h0012; run = 1'b1; mem_write = 1'b1; data_addr = 16'h0041; wdata = 16'h1234;
    tick();                                   // FETCH
    run = 1'b0;
    bus.inputReady = 1'b1; bus.data_in = 16'h2222;
    tick();                                   // EXEC
    bus.inputReady = 1'b0;
    bus.ackOutput = 1'b1;                     // ignored outside WRITE
    tick();                                   // WRITE, first cycle
    bus.ackOutput = 1'b0;
    check_eq("t3_exec_ack_ignored", commit, 0);
    check_eq("t3_writeM", bus.writeM, 1);
    check_eq("t3_data_oe", bus.data_oe, 1);
    check_eq("t3_data_out", bus.data_out, 16'h1234);
    check_eq("t3_addr", bus.address, 16'h0041);
    check_eq("t3_readM", bus.readM, 0);
    tick();                                   // WRITE, second cycle
    check_eq("t3_writeM_2", bus.writeM, 1);
    bus.ackOutput = 1'b1;
    tick();                                   // COMMIT
    bus.ackOutput = 1'b0; mem_write = 1'b0;
    check_eq("t3_commit", commit, 1);
    check_eq("t3_commit_writeM", bus.writeM, 0);
    check_eq("t3_commit_oe", bus.data_oe, 0);
    check_eq("t3_commit_dout", bus.data_out, 16'h0000);
    check_eq("t3_rdata_kept", rdata, 16'hBEEF);
    tick();                                   // IDLE
    check_eq("t3_wr_cycles", wr_cycles, 2);
    check_eq("t3_err", err, 0);

    // Zero-wait back-to-back ALU instructions: 3 cycles each
    clear_counts();
    pc = 16'h0020; run = 1'b1; bus.inputReady = 1'b1; bus.data_in = 16'h0003;
    tick();                                   // FETCH
    tick();                                   // EXEC
    check_eq("bb_exec_commit", commit, 0);
    tick();                                   // COMMIT
    check_eq("bb_commit1", commit, 1);
    tick();                                   // FETCH again
    run = 1'b0;
    check_eq("bb_refetch", bus.readM, 1);
    check_eq("bb_refetch_iv", inst_valid, 0);
    tick();                                   // EXEC
    tick();                                   // COMMIT
    check_eq("bb_commit2", commit, 1);
    tick();                                   // IDLE
    bus.inputReady = 1'b0;
    check_eq("bb_idle_readM", bus.readM, 0);
    check_eq("bb_commits", commits, 2);

    // 4: reset in READ, then restart
    pc = 16'h0030; run = 1'b1; mem_read = 1'b1; data_addr = 16'h0050;
    tick();                                   // FETCH
    bus.inputReady = 1'b1; bus.data_in = 16'h3333;
    tick();                                   // EXEC
    bus.inputReady = 1'b0;
    tick();                                   // READ
    check_eq("t4_read_addr", bus.address, 16'h0050);
    reset = 1'b1;
    tick();                                   // IDLE after reset
    reset = 1'b0; mem_read = 1'b0;
    check_eq("t4_rst_readM", bus.readM, 0);
    check_eq("t4_rst_addr", bus.address, 16'h0000);
    check_eq("t4_rst_inst", inst, 16'h0000);
    check_eq("t4_rst_iv", inst_valid, 0);
    tick();                                   // FETCH
    run = 1'b0;
    check_eq("t4_restart_readM", bus.readM, 1);
    check_eq("t4_restart_addr", bus.address, 16'h0030);
    bus.inputReady = 1'b1; bus.data_in = 16'h4444;
    tick();                                   // EXEC
    bus.inputReady = 1'b0;
    tick();                                   // COMMIT
    check_eq("t4_commit", commit, 1);
    tick();                                   // IDLE

    // 5: load+store decode conflict
    pc = 16'h0031; run = 1'b1; mem_read = 1'b1; mem_write = 1'b1;
    data_addr = 16'h0060; wdata = 16'hA5A5;
    tick();                                   // FETCH
    run = 1'b0;
    bus.inputReady = 1'b1; bus.data_in = 16'h5555;
    tick();                                   // EXEC
    bus.inputReady = 1'b0;
    check_eq("t5_exec_err", err, 0);
    tick();                                   // WRITE
    mem_read = 1'b0; mem_write = 1'b0;
    check_eq("t5_writeM", bus.writeM, 1);
    check_eq("t5_readM", bus.readM, 0);
    check_eq("t5_dout", bus.data_out, 16'hA5A5);
    check_eq("t5_err", err, 1);
    bus.ackOutput = 1'b1;
    tick();                                   // COMMIT
    bus.ackOutput = 1'b0;
    check_eq("t5_commit", commit, 1);
    tick(); tick();                           // IDLE
    check_eq("t5_err_sticky", err, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t5_err_cleared", err, 0);

`ifdef MEM_TIMEOUT_EN
    // 6: fetch never answered -> ERROR after four waiting cycles
    clear_counts();
    pc = 16'h0070; run = 1'b1;
    tick();                                   // FETCH, wait 1
    run = 1'b0;
    tick(); tick(); tick();                   // waits 2..4
    check_eq("t6_wait4_readM", bus.readM, 1);
    check_eq("t6_wait4_err", err, 0);
    tick();                                   // ERROR
    check_eq("t6_err_readM", bus.readM, 0);
    check_eq("t6_err", err, 1);
    bus.inputReady = 1'b1; run = 1'b1;
    tick(); tick(); tick();
    bus.inputReady = 1'b0; run = 1'b0;
    check_eq("t6_stuck_readM", bus.readM, 0);
    check_eq("t6_stuck_err", err, 1);
    check_eq("t6_commits", commits, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t6_reset_err", err, 0);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
